line_doubler: RTL and testbench
===============================

# line_doubler

Parametrised line-buffered scan doubler for the video path. It converts 15 kHz RGB, sampled on an input pixel enable, into 31 kHz VGA timing, sampled on an output pixel enable at twice the rate. Every input line is emitted twice from a ping-pong line buffer. The block generalises the fixed-width doubler in channel count and channel width, with maximum line length set by an address width. It adds an optional scanline mode that dims the repeated line. It sits between the core's video generator and the board RGB/sync pins, with all logic on the system clock.

## Interface
- NCH, 3: number of colour channels.
- CW, 3: bits per channel; pixel word width is NCH*CW, with channel 0 in the MSBs.
- AW, 10: line-buffer address width; maximum captured line length is 2^AW input pixels.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- ice  in  1  input pixel enable, one clock wide.
- ihs  in  1  input hsync, active high, sampled on ice.
- ivs  in  1  input vsync, active high, sampled on ice.
- irgb  in  NCH*CW  input pixel, sampled on ice.
- oce  in  1  output pixel enable, one clock wide, nominally twice the ice rate.
- scan  in  1  scanline mode enable, sampled at each output line start.
- ohs  out  1  output hsync, active high.
- ovs  out  1  output vsync, active high.
- orgb  out  NCH*CW  output pixel.

## Operation
- **Input side (on ice)**
  - icount counts pixels since the last ihs rising edge, sampled as a 0→1 transition between consecutive ice samples.
  - Each sample writes irgb to buffer[wbank][icount].
  - icount saturates at 2^AW-1; at saturation, writes stop until the next line.
  - hsw counts ice ticks while ihs is high after the rise.
- **Line end (ihs rise on ice)**
  - Latch len = icount+1 and latch hsw.
  - Clear icount and toggle wbank.
  - Set valid.
  - Restart the output side: ocount=0, oline=0. This phase-locks output to input.
- **Output side (on oce, when valid)**
  - Read buffer[~wbank][ocount].
  - ocount increments; at ocount==len-1 it wraps to 0 and toggles oline.
  - A second wrap before the next input line end freezes ocount at 0 and drives black until the restart. This covers input lines shorter than the nominal length.
- **ohs** is high while ocount < hsw, with output counts in oce ticks.
- **ovs** is ivs resampled on oce, aligned with the orgb pipeline.
- **Scanline mode**: when oline==1 and scan latched 1, each channel field is shifted right by 1 (logical, per CW field). Otherwise the pixel passes unmodified.
- **Until valid**: ocount holds at 0, and ohs, ovs and orgb stay 0.
- **Buffer**: 2×2^AW words of NCH*CW bits, inferred as simple dual-port RAM.

## Timing
- Reset values: ohs=0, ovs=0, orgb=0, valid=0, wbank=0, icount=0, ocount=0, oline=0, len=0, hsw=0.
- Reset takes effect immediately, mid-line included. The first line after reset is captured but not shown; output starts after the second ihs rise.
- Output latency is 2 oce ticks from read address to orgb/ohs/ovs: 1 tick RAM read plus 1 tick register. ohs, ovs and orgb stay mutually aligned.
- ice and oce may coincide in the same clock; the write and read go to different banks, so there is no conflict.
- ihs rise and an ocount wrap in the same clock: the restart wins, giving ocount=0, oline=0.
- Outputs change only on clocks with oce=1, except under reset.
- Total input-to-output delay: one input line plus 2 oce ticks.

## Test plan
1. **Reset**: hold reset=0 with random stimulus on all inputs → ohs=ovs=0 and orgb=0 throughout; after release, orgb stays 0 until the second ihs rise.
2. **Basic doubling**: NCH=3, CW=3, AW=10, oce=2×ice. Lines of 448 pixels, with ihs high for pixels 0..31 and pixel k = k mod 512. → Each line appears twice; output pixel k equals k mod 512 two oce ticks after address k; ohs is high for 32 oce ticks per output line.
3. **Scanline mode**: scan=1 and all pixels 9'b111_111_111. → First copy outputs 9'h1FF; second copy outputs 9'b011_011_011.
4. **Overflow**: AW=4 with 20-pixel lines → addresses 0..15 hold pixels 0..15; len=16; pixels 16..19 are dropped; output repeats pixels 0..15 twice without corrupting bank contents.
5. **Short line**: a 448-pixel line followed by a 300-pixel line → the second copy of the previous line stops on the restart; ocount resets to 0 at the ihs rise; no black frozen segment appears, since the restart precedes the second wrap.
6. **Vsync and simultaneous enables**: ivs pulse of 3 lines, with ice and oce asserted in the same clock on every ice → ovs is high for 6 output lines (within 2 oce ticks of pipeline skew); no read/write corruption, with data identical to scenario 2.

Source files
------------

// File: rtl/line_doubler.sv
`default_nettype none
// ============================================================================
// line_doubler : ping-pong line-buffer scan doubler (15 kHz -> 31 kHz) with
//                optional scanline dimming of the repeated line.
// Rev 1.0
// ============================================================================
module line_doubler #(
  parameter int NCH = 3,
  parameter int CW  = 3,
  parameter int AW  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ice,
  input  logic              ihs,
  input  logic              ivs,
  input  logic [NCH*CW-1:0] irgb,
  input  logic              oce,
  input  logic              scan,
  output logic              ohs,
  output logic              ovs,
  output logic [NCH*CW-1:0] orgb
);

  localparam int            PW    = NCH * CW;
  localparam int            WORDS = 2 << AW;
  localparam logic [AW-1:0] IMAX  = '1;
  localparam logic [AW:0]   HMAX  = '1;

  logic [PW-1:0] mem [0:WORDS-1];

  // input side
  logic          ihs_q;
  logic [AW-1:0] icount;
  logic [AW:0]   hcnt;
  logic [AW:0]   hsw;
  logic [AW:0]   len;
  logic          wbank;
  logic          armed;
  logic          valid;

  // output side
  logic [AW-1:0] ocount;
  logic          oline;
  logic          frozen;
  logic          scan_l;
  logic [PW-1:0] rdata;
  logic          hs_p;
  logic          vs_p;
  logic          dim_p;
  logic          blank_p;
  logic [PW-1:0] dimmed;

  logic          rise;
  logic          wen;
  logic          wsel;
  logic [AW-1:0] waddr;

  assign rise = ice & ihs & ~ihs_q;

  // The rising-edge sample is pixel 0 of the new line, so it already lands in the next bank.
  always_comb begin
    wsel  = wbank;
    waddr = icount + AW'(1);
    wen   = ice && (icount != IMAX);
    if (rise) begin
      wsel  = ~wbank;
      waddr = '0;
      wen   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ihs_q  <= 1'b0;
      icount <= '0;
      hcnt   <= '0;
      hsw    <= '0;
      len    <= '0;
      wbank  <= 1'b0;
      armed  <= 1'b0;
      valid  <= 1'b0;
    end else if (ice) begin
      ihs_q <= ihs;
      if (rise) begin
        len    <= {1'b0, icount} + (AW+1)'(1);
        hsw    <= hcnt;
        hcnt   <= (AW+1)'(1);
        icount <= '0;
        wbank  <= ~wbank;
        armed  <= 1'b1;
        valid  <= armed;
      end else begin
        if (icount != IMAX) icount <= icount + AW'(1);
        if (ihs && (hcnt != HMAX)) hcnt <= hcnt + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wen) mem[{wsel, waddr}] <= irgb;
    if (oce) rdata <= mem[{~wbank, ocount}];
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign dimmed[c*CW +: CW] = rdata[c*CW +: CW] >> 1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ocount  <= '0;
      oline   <= 1'b0;
      frozen  <= 1'b0;
      scan_l  <= 1'b0;
      hs_p    <= 1'b0;
      vs_p    <= 1'b0;
      dim_p   <= 1'b0;
      blank_p <= 1'b1;
      ohs     <= 1'b0;
      ovs     <= 1'b0;
      orgb    <= '0;
    end else begin
      if (rise) begin
        ocount <= '0;
        oline  <= 1'b0;
        frozen <= 1'b0;
        scan_l <= scan;
      end else if (oce && valid && !frozen) begin
        if ({1'b0, ocount} == len - (AW+1)'(1)) begin
          ocount <= '0;
          // A second wrap means the input line is late: hold black until it arrives.
          if (oline) begin
            frozen <= 1'b1;
          end else begin
            oline  <= 1'b1;
            scan_l <= scan;
          end
        end else begin
          ocount <= ocount + AW'(1);
        end
      end

      if (oce) begin
        hs_p    <= valid & ({1'b0, ocount} < hsw);
        vs_p    <= valid & ivs;
        dim_p   <= oline & scan_l;
        blank_p <= ~valid | frozen;
        ohs     <= hs_p;
        ovs     <= vs_p;
        orgb    <= blank_p ? '0 : (dim_p ? dimmed : rdata);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_doubler.sv
`default_nettype none
// ============================================================================
// tb_line_doubler : scoreboard bench for line_doubler, AW=10 and AW=4 instances.
// Rev 1.0
// ============================================================================
module tb_line_doubler;

  localparam int PW = 9;

  typedef struct {
    int              due;
    logic [PW+1:0]   val;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ice   = 1'b0;
  logic          ihs   = 1'b0;
  logic          ivs   = 1'b0;
  logic          oce   = 1'b0;
  logic          scan  = 1'b0;
  logic [PW-1:0] irgb  = '0;

  logic          ohs_m, ovs_m, ohs_o, ovs_o;
  logic [PW-1:0] orgb_m, orgb_o;

  exp_t q_m[$];
  exp_t q_o[$];
  int   checks = 0;
  int   errors = 0;
  int   otick_s = 0;
  int   otick_m = 0;

  int   rises = 0, pos = 0;
  int   disp_len = 0, disp_h = 0, disp_kind = 0;
  logic disp_sc = 1'b0;
  int   last_len = 0, last_h = 0, last_kind = 0;
  logic push_en = 1'b0;

  always #5 clock = ~clock;

  line_doubler #(.NCH(3), .CW(3), .AW(10)) u_main (
    .clock(clock), .reset(reset), .ice(ice), .ihs(ihs), .ivs(ivs), .irgb(irgb),
    .oce(oce), .scan(scan), .ohs(ohs_m), .ovs(ovs_m), .orgb(orgb_m)
  );

  line_doubler #(.NCH(3), .CW(3), .AW(4)) u_ovf (
    .clock(clock), .reset(reset), .ice(ice), .ihs(ihs), .ivs(ivs), .irgb(irgb),
    .oce(oce), .scan(scan), .ohs(ohs_o), .ovs(ovs_o), .orgb(orgb_o)
  );

  function automatic logic [PW-1:0] pix(input int kind, input int k);
    return (kind == 1) ? 9'h1FF : PW'(k % 512);
  endfunction

  function automatic logic [PW-1:0] dim(input logic [PW-1:0] v);
    return (v >> 1) & 9'b011_011_011;
  endfunction

  // Expected {ohs, ovs, orgb} for the pixel fetched at the current oce tick.
  function automatic logic [PW+1:0] expect_out(input int maxn, input logic vs_in);
    int n, a;
    logic hs;
    logic [PW-1:0] rgb;
    if (rises < 2) return '0;
    n = (disp_len < maxn) ? disp_len : maxn;
    if (pos < 2 * n) begin
      a   = (pos < n) ? pos : pos - n;
      rgb = pix(disp_kind, a);
      if (pos >= n && disp_sc) rgb = dim(rgb);
      hs  = (a < disp_h);
    end else begin
      rgb = '0;
      hs  = (disp_h > 0);
    end
    return {hs, vs_in, rgb};
  endfunction

  task automatic tick(input logic ce_i, input logic ce_o, input logic hs_v, input logic vs_v,
                      input logic sc_v, input logic [PW-1:0] rgb_v, input logic rise);
    @(negedge clock);
    ice = ce_i; oce = ce_o; ihs = hs_v; ivs = vs_v; scan = sc_v; irgb = rgb_v;
    if (ce_o) begin
      otick_s++;
      if (push_en) begin
        q_m.push_back('{otick_s + 1, expect_out(1024, vs_v)});
        q_o.push_back('{otick_s + 1, expect_out(16, vs_v)});
      end
      if (!rise) pos++;
    end
    if (rise) begin
      rises++;
      pos       = 0;
      disp_len  = last_len;
      disp_h    = last_h;
      disp_kind = last_kind;
      disp_sc   = sc_v;
    end
  endtask

  task automatic send_line(input int len, input int h, input int kind, input logic vs, input logic sc);
    for (int k = 0; k < len; k++)
      for (int c = 0; c < 4; c++)
        tick(c == 0, (c % 2) == 0, k < h, vs, sc, pix(kind, k), (k == 0) && (c == 0));
    last_len  = len;
    last_h    = h;
    last_kind = kind;
  endtask

  task automatic check(input string name, input int t, input logic [PW+1:0] act, input logic [PW+1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s otick %0d: got hs=%b vs=%b rgb=%03h, expected hs=%b vs=%b rgb=%03h",
               name, t, act[PW+1], act[PW], act[PW-1:0], exp[PW+1], exp[PW], exp[PW-1:0]);
    end
  endtask

  initial begin : monitor
    logic o;
    exp_t e;
    forever begin
      @(posedge clock);
      o = oce;
      #1;
      if (!reset) begin
        check("reset_main", otick_m, {ohs_m, ovs_m, orgb_m}, '0);
        check("reset_ovf",  otick_m, {ohs_o, ovs_o, orgb_o}, '0);
      end
      if (o) begin
        otick_m++;
        while (q_m.size() > 0 && q_m[0].due < otick_m) begin
          e = q_m.pop_front(); errors++; checks++;
          $display("FAIL sched_main: entry due %0d skipped at %0d", e.due, otick_m);
        end
        while (q_o.size() > 0 && q_o[0].due < otick_m) begin
          e = q_o.pop_front(); errors++; checks++;
          $display("FAIL sched_ovf: entry due %0d skipped at %0d", e.due, otick_m);
        end
        if (q_m.size() > 0 && q_m[0].due == otick_m) begin
          e = q_m.pop_front();
          check("main", otick_m, {ohs_m, ovs_m, orgb_m}, e.val);
        end
        if (q_o.size() > 0 && q_o[0].due == otick_m) begin
          e = q_o.pop_front();
          check("ovf", otick_m, {ohs_o, ovs_o, orgb_o}, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    #2 reset = 1'b0;
    for (int i = 0; i < 120; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), PW'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(negedge clock);
    reset   = 1'b1;
    push_en = 1'b1;

    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 4; c++)
        tick(c == 0, (c % 2) == 0, 1'b0, 1'b0, 1'b0, PW'($urandom), 1'b0);

    send_line(448, 32, 0, 1'b0, 1'b0);
    send_line(448, 32, 0, 1'b0, 1'b0);
    send_line(448, 32, 0, 1'b1, 1'b0);
    send_line(448, 32, 0, 1'b1, 1'b0);
    send_line(448, 32, 0, 1'b1, 1'b0);
    send_line(300, 32, 0, 1'b0, 1'b0);
    send_line(300, 32, 1, 1'b0, 1'b1);
    send_line(300, 32, 1, 1'b0, 1'b1);
    send_line(20,  4,  0, 1'b0, 1'b0);
    send_line(20,  4,  0, 1'b0, 1'b0);
    send_line(20,  4,  0, 1'b0, 1'b0);
    send_line(20,  4,  0, 1'b0, 1'b0);

    push_en = 1'b0;
    for (int i = 0; i < 16; i++) tick(1'b0, (i % 2) == 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 200 && (q_m.size() > 0 || q_o.size() > 0); i++) @(posedge clock);
    checks++;
    if (q_m.size() > 0 || q_o.size() > 0) begin
      errors++;
      $display("FAIL drain: pending main=%0d ovf=%0d, expected 0", q_m.size(), q_o.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
